video_stream_gen: RTL and testbench



---
 rtl/video_stream_gen_if.sv | 24 ++
 rtl/video_stream_gen.sv | 139 +++++++++++++
 tb/tb_video_stream_gen.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_stream_gen_if.sv
// Pixel handshake between an upstream source and the video timing generator.
//   pix_valid : source has a pixel available
//   pix_data  : the pixel
//   pix_ready : sink consumes pix_data this cycle
// master = pixel source, slave = video_stream_gen.
interface video_stream_gen_if #(
    parameter int unsigned DW = 8
) ();
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_ready;

    modport master (
        output pix_valid,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        output pix_ready
    );
endinterface

// File: rtl/video_stream_gen.sv
// Source-side video timing generator feeding the Sobel pipeline.
// Pulls pixels over a valid/ready handshake and emits vsync/hsync/data with fixed frame timing:
// vsync high for V_FRONT_CLK + IH*H_TOTAL clocks, first hsync V_FRONT_CLK clocks after vsync
// rises, IH lines of H_TOTAL clocks with IW active clocks each, then at least V_BACK_CLK clocks
// of vsync low. Timing never stalls; a missing pixel becomes a zero and sets underflow.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   enable      : frames are generated while high (sampled in idle and on the last back-porch
//                 cycle)
//   pix         : upstream pixel handshake (slave side), pix_ready high only in active slots
//   dout_vsync  : frame valid
//   dout_hsync  : line valid
//   dout        : pixel aligned with dout_hsync, zero otherwise
//   frame_done  : one-cycle pulse in the first vsync-low cycle after a completed frame
//   underflow   : sticky, an active slot found pix_valid low
// V_FRONT_CLK, V_BACK_CLK, IW and IH are all expected to be at least 1.
module video_stream_gen #(
    parameter int unsigned DW          = 8,
    parameter int unsigned IW          = 640,
    parameter int unsigned IH          = 480,
    parameter int unsigned H_TOTAL     = 1440,
    parameter int unsigned V_FRONT_CLK = 28800,
    parameter int unsigned V_BACK_CLK  = 28800,
    parameter int unsigned CW          = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    video_stream_gen_if.slave   pix,
    output logic                dout_vsync,
    output logic                dout_hsync,
    output logic [DW-1:0]       dout,
    output logic                frame_done,
    output logic                underflow
);

    localparam logic [CW-1:0] VFrontLast = CW'(V_FRONT_CLK - 1);
    localparam logic [CW-1:0] HActLast   = CW'(IW - 1);
    localparam logic [CW-1:0] HBlankLast = CW'(H_TOTAL - IW - 1);
    localparam logic [CW-1:0] VBackLast  = CW'(V_BACK_CLK - 1);
    localparam logic [CW-1:0] LineLast   = CW'(IH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StVFront,
        StHAct,
        StHBlank,
        StVBack
    } state_e;

    state_e        state_q;
    logic [CW-1:0] clk_cnt_q;
    logic [CW-1:0] line_cnt_q;
    logic          vsync_q;
    logic          hsync_q;
    logic [DW-1:0] dout_q;
    logic          frame_done_q;
    logic          underflow_q;

    // Gated by rst_n so the source never sees a consume while the frame is being aborted.
    assign pix.pix_ready = rst_n && (state_q == StHAct);

    assign dout_vsync = vsync_q;
    assign dout_hsync = hsync_q;
    assign dout       = dout_q;
    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            clk_cnt_q    <= '0;
            line_cnt_q   <= '0;
            vsync_q      <= 1'b0;
            hsync_q      <= 1'b0;
            dout_q       <= '0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            // Outputs reflect the state of the previous cycle.
            vsync_q      <= (state_q == StVFront) || (state_q == StHAct) ||
                            (state_q == StHBlank);
            hsync_q      <= (state_q == StHAct);
            dout_q       <= ((state_q == StHAct) && pix.pix_valid) ? pix.pix_data : '0;
            // First back-porch cycle: vsync drops on the next edge together with this pulse.
            frame_done_q <= (state_q == StVBack) && (clk_cnt_q == '0);
            if ((state_q == StHAct) && !pix.pix_valid) begin
                underflow_q <= 1'b1;
            end

            clk_cnt_q <= clk_cnt_q + CW'(1);

            unique case (state_q)
                StIdle: begin
                    clk_cnt_q <= '0;
                    if (enable) begin
                        state_q    <= StVFront;
                        line_cnt_q <= '0;
                    end
                end
                StVFront: begin
                    if (clk_cnt_q == VFrontLast) begin
                        state_q   <= StHAct;
                        clk_cnt_q <= '0;
                    end
                end
                StHAct: begin
                    if (clk_cnt_q == HActLast) begin
                        state_q   <= StHBlank;
                        clk_cnt_q <= '0;
                    end
                end
                StHBlank: begin
                    if (clk_cnt_q == HBlankLast) begin
                        clk_cnt_q  <= '0;
                        line_cnt_q <= line_cnt_q + CW'(1);
                        state_q    <= (line_cnt_q == LineLast) ? StVBack : StHAct;
                    end
                end
                StVBack: begin
                    if (clk_cnt_q == VBackLast) begin
                        clk_cnt_q <= '0;
                        if (enable) begin
                            state_q    <= StVFront;
                            line_cnt_q <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    clk_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen with small timing parameters
// (IW=4, IH=3, H_TOTAL=7, V_FRONT_CLK=5, V_BACK_CLK=3): one frame is 26 vsync-high cycles.
module tb_video_stream_gen;

    localparam int unsigned DW          = 8;
    localparam int unsigned IW          = 4;
    localparam int unsigned IH          = 3;
    localparam int unsigned H_TOTAL     = 7;
    localparam int unsigned V_FRONT_CLK = 5;
    localparam int unsigned V_BACK_CLK  = 3;
    localparam int unsigned CW          = 8;

    localparam int VsLen  = 26;
    localparam int NSlot  = 12;
    localparam int Tr     = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          dout_vsync;
    logic          dout_hsync;
    logic [DW-1:0] dout;
    logic          frame_done;
    logic          underflow;

    video_stream_gen_if #(.DW(DW)) pix ();

    video_stream_gen #(
        .DW          (DW),
        .IW          (IW),
        .IH          (IH),
        .H_TOTAL     (H_TOTAL),
        .V_FRONT_CLK (V_FRONT_CLK),
        .V_BACK_CLK  (V_BACK_CLK),
        .CW          (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pix        (pix),
        .dout_vsync (dout_vsync),
        .dout_hsync (dout_hsync),
        .dout       (dout),
        .frame_done (frame_done),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Upstream source state and trace of DUT outputs, one entry per cycle.
    int  word    = 1;
    bit  fire    = 1'b0;
    int  slot_cnt = 0;
    bit  drop_en = 1'b0;
    int  drop_at = 0;
    int  cyc     = 0;

    logic          tr_vs  [Tr];
    logic          tr_hs  [Tr];
    logic          tr_fd  [Tr];
    logic          tr_uf  [Tr];
    logic          tr_rdy [Tr];
    logic [DW-1:0] tr_d   [Tr];

    task automatic check(input string tag, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Source model: words 1,2,3... advancing on each accepted handshake. Runs 2ns after the
    // falling edge so it sees inputs the main thread set on that edge.
    initial begin
        pix.pix_valid = 1'b1;
        pix.pix_data  = DW'(word);
        forever begin
            @(negedge clk);
            #2;
            if (fire) word++;
            pix.pix_data  = DW'(word);
            pix.pix_valid = !(drop_en && pix.pix_ready && (slot_cnt == drop_at));
            fire = pix.pix_ready && pix.pix_valid;
            if (pix.pix_ready) slot_cnt++;
            if (cyc < Tr) begin
                tr_vs[cyc]  = dout_vsync;
                tr_hs[cyc]  = dout_hsync;
                tr_fd[cyc]  = frame_done;
                tr_uf[cyc]  = underflow;
                tr_rdy[cyc] = pix.pix_ready;
                tr_d[cyc]   = dout;
            end
            cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_trace();
        cyc      = 0;
        slot_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    // Checks one frame found at or after index 'from'. drop < 0 means no slot was starved.
    task automatic analyze(input string tag, input int from, input int start, input int drop,
                           output int rise, output int len, output int dpos);
        int n, k, w, e, hi, nz, fd_cnt, rdy_cnt, rdy_bad;
        int pos [NSlot];
        n    = (cyc < Tr) ? cyc : Tr;
        rise = -1;
        len  = 0;
        dpos = -1;
        for (int i = from; i < n; i++) begin
            if (tr_vs[i] && (i == 0 || !tr_vs[i-1])) begin
                rise = i;
                break;
            end
        end
        check({tag, "_vs_rise_found"}, (rise >= 0) ? 1 : 0, 1);
        if (rise < 0) return;
        while (rise + len < n && tr_vs[rise+len]) len++;
        check({tag, "_vs_len"}, len, VsLen);

        k = 0;
        for (int i = rise; i < rise + len; i++) begin
            if (tr_hs[i]) begin
                if (k == drop)                  e = 0;
                else if (drop >= 0 && k > drop) e = start + k - 1;
                else                            e = start + k;
                if (k < NSlot) pos[k] = i;
                check($sformatf("%s_dout_slot%0d", tag, k), int'(tr_d[i]), e);
                k++;
            end
        end
        check({tag, "_slots"}, k, NSlot);
        if (k == NSlot) begin
            check({tag, "_first_hs_offset"}, pos[0] - rise, 5);
            for (int l = 0; l < 3; l++) begin
                w = 0;
                while (pos[4*l] + w < n && tr_hs[pos[4*l]+w]) w++;
                check($sformatf("%s_hs_width_line%0d", tag, l), w, 4);
                if (l < 2) check($sformatf("%s_hs_period_line%0d", tag, l),
                                 pos[4*(l+1)] - pos[4*l], 7);
            end
            if (drop >= 0 && drop < NSlot) dpos = pos[drop];
        end

        hi = rise + len + 3;
        if (hi >= n) hi = n - 1;
        nz = 0; fd_cnt = 0; rdy_cnt = 0; rdy_bad = 0;
        for (int i = from; i <= hi; i++) begin
            if (!tr_hs[i] && tr_d[i] != '0) nz++;
            if (tr_fd[i]) fd_cnt++;
            if (tr_rdy[i]) begin
                rdy_cnt++;
                if (i + 1 >= n || !tr_hs[i+1]) rdy_bad++;
            end
        end
        check({tag, "_dout_zero_when_idle"}, nz, 0);
        check({tag, "_frame_done_count"}, fd_cnt, 1);
        if (rise + len < n) check({tag, "_frame_done_pos"}, int'(tr_fd[rise+len]), 1);
        check({tag, "_ready_count"}, rdy_cnt, NSlot);
        check({tag, "_ready_then_hsync"}, rdy_bad, 0);
    endtask

    initial begin
        int r1, l1, r2, l2, dp, s, vs_after, rdy_after, n;

        rst_n  = 1'b0;
        enable = 1'b0;

        // Reset state after the first edge with rst_n low.
        @(negedge clk);
        check("rst_vsync",      int'(dout_vsync),    0);
        check("rst_hsync",      int'(dout_hsync),    0);
        check("rst_dout",       int'(dout),          0);
        check("rst_frame_done", int'(frame_done),    0);
        check("rst_underflow",  int'(underflow),     0);
        check("rst_pix_ready",  int'(pix.pix_ready), 0);

        // Two back-to-back frames with enable held.
        rst_n  = 1'b1;
        enable = 1'b1;
        start_trace();
        tick(75);
        analyze("s1f1", 0, 1, -1, r1, l1, dp);
        analyze("s1f2", r1 + l1 + 1, 13, -1, r2, l2, dp);
        check("s1_vsync_gap", r2 - (r1 + l1), 3);
        check("s1_underflow_clear", int'(tr_uf[cyc-1]), 0);

        // Starve the 2nd slot of line 2 (slot index 5).
        do_reset();
        s       = word;
        drop_en = 1'b1;
        drop_at = 5;
        enable  = 1'b1;
        start_trace();
        tick(40);
        analyze("s2", 0, s, 5, r1, l1, dp);
        check("s2_drop_slot_found", (dp > 0) ? 1 : 0, 1);
        if (dp > 0) begin
            check("s2_underflow_before", int'(tr_uf[dp-1]), 0);
            check("s2_underflow_rise",   int'(tr_uf[dp]),   1);
        end
        check("s2_underflow_sticky", int'(tr_uf[cyc-1]), 1);
        drop_en = 1'b0;

        // Drop enable during line 2: frame completes, then the generator stays idle.
        do_reset();
        s      = word;
        enable = 1'b1;
        start_trace();
        tick(14);
        enable = 1'b0;
        tick(50);
        analyze("s3", 0, s, -1, r1, l1, dp);
        n = (cyc < Tr) ? cyc : Tr;
        vs_after  = 0;
        rdy_after = 0;
        for (int i = r1 + l1 + 1; i < n; i++) begin
            if (tr_vs[i])  vs_after++;
            if (tr_rdy[i]) rdy_after++;
        end
        check("s3_vsync_after", vs_after, 0);
        check("s3_ready_after", rdy_after, 0);

        // Reset in the middle of line 1 after a starved first slot.
        do_reset();
        drop_en = 1'b1;
        drop_at = 0;
        enable  = 1'b1;
        start_trace();
        tick(7);
        check("s4_underflow_set", int'(underflow), 1);
        drop_en = 1'b0;
        rst_n   = 1'b0;
        tick(1);
        check("s4_rst_vsync",      int'(dout_vsync),    0);
        check("s4_rst_hsync",      int'(dout_hsync),    0);
        check("s4_rst_dout",       int'(dout),          0);
        check("s4_rst_frame_done", int'(frame_done),    0);
        check("s4_rst_underflow",  int'(underflow),     0);
        check("s4_rst_pix_ready",  int'(pix.pix_ready), 0);
        rst_n = 1'b1;
        s     = word;
        start_trace();
        tick(40);
        analyze("s4", 0, s, -1, r1, l1, dp);
        check("s4_underflow_end", int'(tr_uf[cyc-1]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
